// File: rtl/frame_shiftregister.sv
// Frame-aware parallel-load shift register for the SPI datapath: per-frame bit order
// and length, self-counted frame end with a one-cycle frameDone. Optional PARITY_EN adds parityOut.
module frame_shiftregister #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             peripheralClkEdge,
    input  logic             parallelLoad,
    input  logic [WIDTH-1:0] parallelDataIn,
    input  logic             serialDataIn,
    input  logic             msbFirst,
    input  logic [CNT_W-1:0] frameLen,
    output logic [WIDTH-1:0] parallelDataOut,
    output logic             serialDataOut,
    output logic             busy,
    output logic             frameDone,
    output logic             parityOut
);

    localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(WIDTH);

    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_len;
    logic             r_msb;
    logic             r_busy;
    logic             r_done;

    logic [CNT_W-1:0] w_eff_len;
    logic             w_shift;
    logic             w_last;

    // Zero or oversize lengths fall back to a full-width frame.
    assign w_eff_len = (frameLen == '0 || frameLen > FULL_LEN) ? FULL_LEN : frameLen;
    assign w_shift   = !parallelLoad && peripheralClkEdge && r_busy;
    assign w_last    = (r_cnt == r_len - CNT_W'(1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_msb   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (parallelLoad) begin
                r_shreg <= parallelDataIn;
                r_cnt   <= '0;
                r_len   <= w_eff_len;
                r_msb   <= msbFirst;
                r_busy  <= 1'b1;
            end else if (w_shift) begin
                if (r_msb) r_shreg <= {r_shreg[WIDTH-2:0], serialDataIn};
                else       r_shreg <= {serialDataIn, r_shreg[WIDTH-1:1]};
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

`ifdef PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)           r_parity <= 1'b0;
        else if (parallelLoad) r_parity <= 1'b0;
        else if (w_shift)      r_parity <= r_parity ^ serialDataIn;
    end

    assign parityOut = r_parity;
`else
    assign parityOut = 1'b0;
`endif

    assign parallelDataOut = r_shreg;
    assign serialDataOut   = r_msb ? r_shreg[WIDTH-1] : r_shreg[0];
    assign busy            = r_busy;
    assign frameDone       = r_done;

endmodule

// File: tb/tb_frame_shiftregister.sv
// Randomized and directed bench for frame_shiftregister against a word-level reference model.
// Define PARITY_EN for both bench and RTL to exercise the parity build.
module tb_frame_shiftregister;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             resetN;
    logic             peripheralClkEdge;
    logic             parallelLoad;
    logic [WIDTH-1:0] parallelDataIn;
    logic             serialDataIn;
    logic             msbFirst;
    logic [CNT_W-1:0] frameLen;
    logic [WIDTH-1:0] parallelDataOut;
    logic             serialDataOut;
    logic             busy;
    logic             frameDone;
    logic             parityOut;

    int checks = 0;
    int failures = 0;

    // Reference model: the frame as a word, a bit tally and a done flag.
    int m_word;
    int m_len;
    int m_msb;
    int m_shifted;
    int m_busy;
    int m_done;
    int m_ones;

    frame_shiftregister #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .resetN           (resetN),
        .peripheralClkEdge(peripheralClkEdge),
        .parallelLoad     (parallelLoad),
        .parallelDataIn   (parallelDataIn),
        .serialDataIn     (serialDataIn),
        .msbFirst         (msbFirst),
        .frameLen         (frameLen),
        .parallelDataOut  (parallelDataOut),
        .serialDataOut    (serialDataOut),
        .busy             (busy),
        .frameDone        (frameDone),
        .parityOut        (parityOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_word = 0; m_len = 0; m_msb = 1; m_shifted = 0;
        m_busy = 0; m_done = 0; m_ones = 0;
    endtask

    task automatic model_edge();
        int mask;
        mask = (1 << WIDTH) - 1;
        m_done = 0;
        if (parallelLoad) begin
            m_word    = int'(parallelDataIn);
            m_shifted = 0;
            m_ones    = 0;
            m_msb     = int'(msbFirst);
            m_len     = (frameLen == 0 || int'(frameLen) > WIDTH) ? WIDTH : int'(frameLen);
            m_busy    = 1;
        end else if (peripheralClkEdge && m_busy == 1) begin
            if (m_msb == 1) m_word = ((m_word * 2) + int'(serialDataIn)) & mask;
            else            m_word = (m_word / 2) + int'(serialDataIn) * (1 << (WIDTH - 1));
            m_shifted++;
            m_ones += int'(serialDataIn);
            if (m_shifted == m_len) begin
                m_busy = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        int exp_sdo;
        exp_sdo = (m_msb == 1) ? (m_word >> (WIDTH - 1)) & 1 : m_word & 1;
        check({tag, ".pdo"}, 32'(parallelDataOut), 32'(m_word));
        check({tag, ".sdo"}, 32'(serialDataOut), 32'(exp_sdo));
        check({tag, ".busy"}, 32'(busy), 32'(m_busy));
        check({tag, ".done"}, 32'(frameDone), 32'(m_done));
`ifdef PARITY_EN
        check({tag, ".par"}, 32'(parityOut), 32'(m_ones % 2));
`else
        check({tag, ".par"}, 32'(parityOut), 32'd0);
`endif
    endtask

    // Drive one cycle of inputs, step the model on the edge, then compare.
    task automatic cyc(input string tag, input logic ld, input logic [WIDTH-1:0] d,
                       input logic stb, input logic sdi, input logic msb,
                       input logic [CNT_W-1:0] len);
        parallelLoad      = ld;
        parallelDataIn    = d;
        peripheralClkEdge = stb;
        serialDataIn      = sdi;
        msbFirst          = msb;
        frameLen          = len;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset(input string tag);
        #2;
        resetN = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] seq;
        logic [7:0] bits6;
        logic [7:0] r;

        resetN = 1'b0;
        parallelLoad = 1'b0; parallelDataIn = '0; peripheralClkEdge = 1'b0;
        serialDataIn = 1'b0; msbFirst = 1'b0; frameLen = '0;
        model_reset();
        @(negedge clk);
        check_all("por");
        @(negedge clk);
        resetN = 1'b1;

        // Reset aborts a frame mid-flight
        cyc("t1_load", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 3; i++) cyc("t1_stb", 1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
        do_reset("t1_rst");
        check("t1_rst_pdo", 32'(parallelDataOut), 32'h0);
        for (int i = 0; i < 10; i++) cyc("t1_post", 1'b0, '0, 1'b1, 1'b1, 1'b0, '0);

        // MSB-first full frame
        seq = 8'hA5;
        cyc("t2_load", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 8; i++) begin
            check("t2_sdo_seq", 32'(serialDataOut), 32'(seq[7-i]));
            cyc("t2_stb", 1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
        end
        check("t2_done", 32'(frameDone), 32'd1);
        check("t2_final", 32'(parallelDataOut), 32'hFF);
        idle("t2_idle");
        check("t2_done_drop", 32'(frameDone), 32'd0);
        cyc("t2_stb9", 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        check("t2_hold", 32'(parallelDataOut), 32'hFF);

        // LSB-first full frame
        seq = 8'b0000_0001;
        cyc("t3_load", 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 4'd8);
        for (int i = 0; i < 8; i++) begin
            check("t3_sdo_seq", 32'(serialDataOut), 32'(seq[7-i]));
            cyc("t3_stb", 1'b0, '0, 1'b1, (i == 0), 1'b0, '0);
        end
        check("t3_final", 32'(parallelDataOut), 32'h01);
        check("t3_done", 32'(frameDone), 32'd1);
        idle("t3_idle");

        // Partial 3-bit frame
        seq = 8'b0000_0101;
        cyc("t4_load", 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3);
        for (int i = 0; i < 3; i++) cyc("t4_stb", 1'b0, '0, 1'b1, seq[2-i], 1'b0, '0);
        check("t4_done", 32'(frameDone), 32'd1);
        check("t4_final", 32'(parallelDataOut), 32'h05);
        cyc("t4_stb4", 1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
        check("t4_hold", 32'(parallelDataOut), 32'h05);

        // Load/strobe collision, then abort-and-restart
        cyc("t5_load", 1'b1, 8'h0F, 1'b1, 1'b1, 1'b1, 4'd0);
        check("t5_collide", 32'(parallelDataOut), 32'h0F);
        for (int i = 0; i < 2; i++) cyc("t5_stb", 1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
        cyc("t5_reload", 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1, 4'd0);
        check("t5_reload_pdo", 32'(parallelDataOut), 32'hF0);
        check("t5_reload_busy", 32'(busy), 32'd1);
        check("t5_reload_done", 32'(frameDone), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cyc("t5_stb2", 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
            check("t5_done_at", 32'(frameDone), (i == 7) ? 32'd1 : 32'd0);
        end
        idle("t5_idle");

        // Parity of 1,1,0,1,0,0,0,0
        bits6 = 8'b1101_0000;
        cyc("t6_load", 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 8; i++) cyc("t6_stb", 1'b0, '0, 1'b1, bits6[7-i], 1'b0, '0);
`ifdef PARITY_EN
        check("t6_par", 32'(parityOut), 32'd1);
`else
        check("t6_par", 32'(parityOut), 32'd0);
`endif
        idle("t6_hold");
        idle("t6_hold2");
        cyc("t6_reload", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 4'd5);
        check("t6_par_clr", 32'(parityOut), 32'd0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd_rst");
            end else begin
                r = 8'($urandom);
                cyc("rnd", ($urandom_range(0, 11) == 0), r, 1'($urandom_range(0, 1)),
                    1'($urandom), 1'($urandom), 4'($urandom_range(0, 15)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
